// File: rtl/multiword_add_seq.sv
// multiword_add_seq: wide (N*WORDS-bit) add/subtract performed one N-bit word
// per clock through a single shared riple_carry_adder, with the inter-word
// carry held in a register. Operands in and results out over valid/ready.
//
// Build option: define MULTIWORD_SUB_EN to enable A-B via the `sub` input.
// Without it `sub` is ignored and only addition is performed.

// Plain N-bit ripple-carry adder used as the shared narrow datapath.
module riple_carry_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    // Bit-serial carry ripple from LSB to MSB.
    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[N];
    end

endmodule

module multiword_add_seq #(
    parameter int unsigned N     = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   op_a,
    input  logic [N*WORDS-1:0]   op_b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   result,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);

    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [WORDS-1:0][N-1:0]   a_q, a_d;
    logic [WORDS-1:0][N-1:0]   b_q, b_d;
    logic [WORDS-1:0][N-1:0]   result_q, result_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      carry_q, carry_d;
    logic                      cout_q, cout_d;
    logic                      ovf_q, ovf_d;

    // sub_acc: effective sub flag at acceptance; sub_run: flag of the op in flight.
    logic                      sub_acc;
    logic                      sub_run;

`ifdef MULTIWORD_SUB_EN
    logic                      sub_q, sub_d;
    assign sub_acc = sub;
    assign sub_run = sub_q;
`else
    logic                      unused_sub;
    assign unused_sub = sub;
    assign sub_acc    = 1'b0;
    assign sub_run    = 1'b0;
`endif

    logic [N-1:0]              a_word;
    logic [N-1:0]              b_word;
    logic [N-1:0]              b_add;
    logic [N-1:0]              add_sum;
    logic                      add_cout;
    logic                      last_word;

    // Word mux feeding the shared adder; B is inverted only for subtraction.
    always_comb begin
        a_word    = a_q[idx_q];
        b_word    = b_q[idx_q];
`ifdef MULTIWORD_SUB_EN
        b_add     = sub_run ? ~b_word : b_word;
`else
        b_add     = b_word;
`endif
        last_word = (idx_q == IW'(WORDS - 1));
    end

    riple_carry_adder #(
        .N (N)
    ) u_adder (
        .a    (a_word),
        .b    (b_add),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
`ifdef MULTIWORD_SUB_EN
        sub_d    = sub_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
`ifdef MULTIWORD_SUB_EN
                    sub_d   = sub_acc;
`endif
                    idx_d   = '0;
                    carry_d = sub_acc;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                result_d[idx_q] = add_sum;
                carry_d         = add_cout;
                idx_d           = idx_q + IW'(1);
                if (last_word) begin
                    // Wrap explicitly so a non-power-of-two WORDS never leaves idx out of range.
                    idx_d   = '0;
                    cout_d  = add_cout;
                    ovf_d   = (a_word[N-1] == b_add[N-1]) && (add_sum[N-1] != a_word[N-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state registers, cleared asynchronously so in-flight work is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef MULTIWORD_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
`ifdef MULTIWORD_SUB_EN
            sub_q    <= sub_d;
`endif
        end
    end

    // Handshake flags decode the registered state only.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_RUN);
        result    = result_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

    localparam int unsigned N     = 8;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = N * WORDS;
    localparam int unsigned W1    = 8;

`ifdef MULTIWORD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main DUT (N=8, WORDS=4)
    logic          in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
    logic [W-1:0]  op_a, op_b, result;

    // Single-word DUT (N=8, WORDS=1)
    logic          in_valid1, in_ready1, sub1, out_valid1, out_ready1, cout1, ovf1, busy1;
    logic [W1-1:0] op_a1, op_b1, result1;

    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .cout(cout), .ovf(ovf), .busy(busy)
    );

    multiword_add_seq #(.N(8), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .result(result1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        longint unsigned r;
        bit              c;
        bit              o;
        int unsigned     t_acc;
    } exp_t;

    exp_t sb[$];
    exp_t sb1[$];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Arithmetic reference: w-bit modular add/sub with carry/no-borrow and signed overflow.
    function automatic exp_t model(input longint unsigned a, input longint unsigned b,
                                   input bit s, input int unsigned w, input int unsigned t);
        exp_t            e;
        longint unsigned mask;
        longint unsigned full;
        bit              sa, sbb, sr;
        mask = (64'd1 << w) - 64'd1;
        sa   = bit'((a >> (w - 1)) & 64'd1);
        sbb  = bit'((b >> (w - 1)) & 64'd1);
        if (s && SUB_EN) begin
            e.r = (a - b) & mask;
            e.c = (a >= b);
            sr  = bit'((e.r >> (w - 1)) & 64'd1);
            e.o = (sa != sbb) && (sr != sa);
        end else begin
            full = a + b;
            e.r  = full & mask;
            e.c  = bit'((full >> w) & 64'd1);
            sr   = bit'((e.r >> (w - 1)) & 64'd1);
            e.o  = (sa == sbb) && (sr != sa);
        end
        e.t_acc = t;
        return e;
    endfunction

    // Scoreboard monitor for the 4-word DUT.
    initial begin : mon
        bit   prev = 1'b0;
        bit   have = 1'b0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                have = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev) begin
                        if (sb.size() == 0) begin
                            check("unexpected_out_valid", 1, 0);
                            have = 1'b0;
                        end else begin
                            cur  = sb.pop_front();
                            have = 1'b1;
                            check("latency", cyc - cur.t_acc, WORDS);
                            check("result", result, cur.r);
                            check("cout", cout, cur.c);
                            check("ovf", ovf, cur.o);
                        end
                    end else if (have) begin
                        check("result_hold", result, cur.r);
                    end
                    check("in_ready_in_done", in_ready, 0);
                end
                prev = out_valid;
            end
        end
    end

    // Scoreboard monitor for the 1-word DUT.
    initial begin : mon1
        bit   prev = 1'b0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (out_valid1 && !prev) begin
                    if (sb1.size() == 0) begin
                        check("w1_unexpected_out_valid", 1, 0);
                    end else begin
                        cur = sb1.pop_front();
                        check("w1_latency", cyc - cur.t_acc, 1);
                        check("w1_result", result1, cur.r);
                        check("w1_cout", cout1, cur.c);
                        check("w1_ovf", ovf1, cur.o);
                    end
                end
                prev = out_valid1;
            end
        end
    end

    // Issue one operation on the 4-word DUT; bp = cycles of backpressure in DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input int unsigned bp);
        int unsigned k;
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        sub      = s;
        sb.push_back(model(a, b, s, W, cyc + 1));
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        sub      = 1'($urandom);
        check("busy_in_run", busy, 1);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        for (int unsigned i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            op_a     = $urandom;
            op_b     = $urandom;
            @(negedge clk);
            check("no_accept_in_done", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_handshake", in_ready, 1);
        check("out_valid_dropped", out_valid, 0);
    endtask

    // Issue one operation on the 1-word DUT.
    task automatic run_op1(input logic [W1-1:0] a, input logic [W1-1:0] b, input bit s);
        int unsigned k;
        in_valid1 = 1'b1;
        op_a1     = a;
        op_b1     = b;
        sub1      = s;
        sb1.push_back(model(a, b, s, W1, cyc + 1));
        @(negedge clk);
        in_valid1 = 1'b0;
        k = 0;
        while (!out_valid1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid1) begin
            check("w1_out_valid_timeout", 0, 1);
            void'(sb1.pop_front());
            return;
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check("w1_idle_after_handshake", in_ready1, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        bit seen_valid;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        sub        = 1'b0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        op_a1      = '0;
        op_b1      = '0;
        sub1       = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_w1_in_ready", in_ready1, 1);
        rst = 1'b0;
        @(negedge clk);

        // Reset one cycle into RUN discards the operation
        in_valid = 1'b1;
        op_a     = 32'h0000_00FF;
        op_b     = 32'h0000_0001;
        sub      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("midrun_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_result", result, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_cout", cout, 0);
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (WORDS + 2) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrun_no_out_valid", seen_valid, 0);
        check("midrun_result_zero", result, 0);

        // Directed vectors
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 2);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);

        // Randomized vectors
        for (int i = 0; i < 24; i++) begin
            run_op($urandom, $urandom, 1'($urandom), $urandom_range(0, 3));
        end

        // Single-word instance
        run_op1(8'hC8, 8'h64, 1'b1);
        run_op1(8'hFF, 8'h01, 1'b0);
        run_op1(8'h7F, 8'h01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_op1(8'($urandom), 8'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("sb1_drained", sb1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
